pipe_adder: RTL

- Parametrised, pipelined successor to the combinational `adder`.
- Splits a WIDTH-bit add/subtract into STAGES equal carry-chain slices, one register stage per slice.
- Uses a valid/ready handshake with backpressure.
- Sits between operand registers and the ALU result mux; keeps the `sum`/`carry`/`tot` result format and adds a signed-overflow flag.

---
 rtl/adder_pkg.sv | 25 ++
 rtl/adder_stage.sv | 49 ++++
 rtl/pipe_adder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder: operation encoding,
// slice-width calculation and saturation constant generators.
package adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Saturation constants are built at this width and truncated by the caller.
   localparam int SAT_MAXW = 64;

   function automatic int slice_w(int width, int stages);
      return width / stages;
   endfunction

   function automatic logic [SAT_MAXW-1:0] sat_pos(int width);
      return (SAT_MAXW'(1) << (width - 1)) - SAT_MAXW'(1);
   endfunction

   function automatic logic [SAT_MAXW-1:0] sat_neg(int width);
      return SAT_MAXW'(1) << (width - 1);
   endfunction

endpackage

// File: rtl/adder_stage.sv
// One carry-chain slice of the pipelined adder: a C-bit add whose sum,
// carry-out, signed-overflow and valid bit are registered when the pipeline advances.
module adder_stage #(
   parameter int C = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         i_en,
   input  logic         i_valid,
   input  logic [C-1:0] i_a,
   input  logic [C-1:0] i_b,
   input  logic         i_cin,
   output logic [C-1:0] o_sum,
   output logic         o_cout,
   output logic         o_ovf,
   output logic         o_valid
);

   logic [C:0]   w_full;
   logic         w_cmsb;
   logic [C-1:0] r_sum;
   logic         r_cout;
   logic         r_ovf;
   logic         r_vld;

   assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{C{1'b0}}, i_cin};
   // Carry into the top bit is recovered from the top sum bit and its operands.
   assign w_cmsb = w_full[C-1] ^ i_a[C-1] ^ i_b[C-1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_vld  <= 1'b0;
      end else if (i_en) begin
         r_sum  <= w_full[C-1:0];
         r_cout <= w_full[C];
         r_ovf  <= w_full[C] ^ w_cmsb;
         r_vld  <= i_valid;
      end
   end

   assign o_sum   = r_sum;
   assign o_cout  = r_cout;
   assign o_ovf   = r_ovf;
   assign o_valid = r_vld;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract split into STAGES carry-chain slices with
// valid/ready backpressure. Define ADDER_SAT_EN to add the sat_i saturating mode.
module pipe_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
`ifdef ADDER_SAT_EN
   input  logic             sat_i,
`endif
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic [WIDTH:0]   tot,
   output logic             ovf_o
);

   localparam int C = slice_w(WIDTH, STAGES);

   op_e              w_op;
   logic             w_en;
   logic [STAGES:0]  w_vld_pipe;
   logic [WIDTH-1:0] w_bx;
   logic [WIDTH-1:0] w_sum_raw;
   logic [C-1:0]     w_sa  [STAGES];
   logic [C-1:0]     w_sb  [STAGES];
   logic [C-1:0]     w_sum [STAGES];
   logic             w_cin [STAGES];
   logic             w_cout[STAGES];
   logic             w_ovf [STAGES];

   // [level][slice]: operand slices still waiting for their stage, and result
   // slices already computed that wait for the rest of their beat.
   logic [C-1:0]     r_ask [STAGES][STAGES];
   logic [C-1:0]     r_bsk [STAGES][STAGES];
   logic [C-1:0]     r_dsk [STAGES][STAGES];

   assign w_vld_pipe[0] = valid_i;
   assign valid_o       = w_vld_pipe[STAGES];
   assign w_en          = !valid_o || ready_i;
   assign ready_o       = w_en;
   assign w_op          = op_e'(sub_i);
   assign w_bx          = (w_op == OP_SUB) ? ~b_i : b_i;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      if (k == 0) begin : g_first
         assign w_sa[k]  = a_i[C-1:0];
         assign w_sb[k]  = w_bx[C-1:0];
         assign w_cin[k] = sub_i;
      end else begin : g_next
         assign w_sa[k]  = r_ask[k-1][k];
         assign w_sb[k]  = r_bsk[k-1][k];
         assign w_cin[k] = w_cout[k-1];
      end

      adder_stage #(.C(C)) u_stage (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .i_en    (w_en),
         .i_valid (w_vld_pipe[k]),
         .i_a     (w_sa[k]),
         .i_b     (w_sb[k]),
         .i_cin   (w_cin[k]),
         .o_sum   (w_sum[k]),
         .o_cout  (w_cout[k]),
         .o_ovf   (w_ovf[k]),
         .o_valid (w_vld_pipe[k+1])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < STAGES; k++) begin
            for (int j = 0; j < STAGES; j++) begin
               r_ask[k][j] <= '0;
               r_bsk[k][j] <= '0;
               r_dsk[k][j] <= '0;
            end
         end
      end else if (w_en) begin
         for (int j = 1; j < STAGES; j++) begin
            r_ask[0][j] <= a_i[j*C +: C];
            r_bsk[0][j] <= w_bx[j*C +: C];
         end
         for (int k = 1; k < STAGES; k++) begin
            for (int j = 0; j < STAGES; j++) begin
               if (j > k) begin
                  r_ask[k][j] <= r_ask[k-1][j];
                  r_bsk[k][j] <= r_bsk[k-1][j];
               end
               if (j == k - 1) r_dsk[k][j] <= w_sum[k-1];
               else if (j < k - 1) r_dsk[k][j] <= r_dsk[k-1][j];
            end
         end
      end
   end

   always_comb begin
      w_sum_raw = '0;
      for (int j = 0; j < STAGES - 1; j++) w_sum_raw[j*C +: C] = r_dsk[STAGES-1][j];
      w_sum_raw[(STAGES-1)*C +: C] = w_sum[STAGES-1];
   end

   assign carry = w_cout[STAGES-1];
   assign ovf_o = w_ovf[STAGES-1];

`ifdef ADDER_SAT_EN
   localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
   localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));

   logic [STAGES-1:0] r_sat;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sat <= '0;
      end else if (w_en) begin
         r_sat[0] <= sat_i;
         for (int k = 1; k < STAGES; k++) r_sat[k] <= r_sat[k-1];
      end
   end

   // Overflow with carry-out set means both operands were negative.
   assign sum = (r_sat[STAGES-1] && ovf_o) ? (carry ? SAT_NEG : SAT_POS) : w_sum_raw;
`else
   assign sum = w_sum_raw;
`endif

   assign tot = {carry, sum};

endmodule
